// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and default geometry for conv_engine.
package conv_pkg;

    localparam int unsigned LEN_DEF  = 16;
    localparam int unsigned K_DEF    = 4;
    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned AW_DEF   = 8;
    localparam int unsigned ACCW_DEF = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed DW x DW multiply, sign-extended into an ACCW accumulator.
// Clear has priority over enable; both are synchronous.
module conv_mac
    import conv_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    localparam int unsigned PW = 2 * DW;

    logic signed [PW-1:0] prod_c;
    logic [ACCW-1:0]      acc_d;
    logic [ACCW-1:0]      acc_q;

    // Full-width signed product, then clear / accumulate selection
    always_comb begin
        prod_c = PW'($signed(a)) * PW'($signed(b));
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACCW'(prod_c);
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv_engine.sv
// conv_engine: sequential 1-D convolution over internal memories.
// Each output takes K MAC cycles plus one WRITE cycle; done pulses once per run.
// Optional feature macro: CONV_RELU_EN clamps negative results to zero on write.
module conv_engine
    import conv_pkg::*;
#(
    parameter int unsigned LEN       = LEN_DEF,
    parameter int unsigned K         = K_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned ACCW      = ACCW_DEF,
    parameter string       IN_FILE   = "input.hex",
    parameter string       FILT_FILE = "filter.hex"
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] x,
    input  logic [AW-1:0] y,
    input  logic [AW-1:0] z,
    output logic          done
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned OW    = $clog2(LEN + 1);
    localparam int unsigned KW    = $clog2(K + 1);

    logic [DW-1:0]   in_mem   [0:DEPTH-1];
    logic [DW-1:0]   filt_mem [0:DEPTH-1];
    logic [ACCW-1:0] out_mem  [0:DEPTH-1];

    // Output memory starts cleared; input and filter images are loaded by the environment
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) out_mem[i] = '0;
    end

    conv_state_t     state_q, state_d;
    logic [AW-1:0]   x_q, x_d;
    logic [AW-1:0]   y_q, y_d;
    logic [AW-1:0]   z_q, z_d;
    logic [OW-1:0]   o_q, o_d;
    logic [KW-1:0]   k_q, k_d;
    logic            done_q, done_d;

    logic            mac_clr_c;
    logic            mac_en_c;
    logic [AW-1:0]   rd_x_c;
    logic [AW-1:0]   rd_y_c;
    logic [AW-1:0]   wr_addr_c;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] wr_data_c;

    // Wrapping address generation for the current tap and output slot
    always_comb begin
        rd_x_c    = x_q + AW'(o_q) + AW'(k_q);
        rd_y_c    = y_q + AW'(k_q);
        wr_addr_c = z_q + AW'(o_q);
    end

    conv_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_c),
        .en  (mac_en_c),
        .a   (in_mem[rd_x_c]),
        .b   (filt_mem[rd_y_c]),
        .acc (acc)
    );

    // Write-back value, optionally rectified
    always_comb begin
`ifdef CONV_RELU_EN
        wr_data_c = acc[ACCW-1] ? '0 : acc;
`else
        wr_data_c = acc;
`endif
    end

    // Next-state, counter and control decode
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        o_d       = o_q;
        k_d       = k_q;
        mac_clr_c = 1'b0;
        mac_en_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = x;
                    y_d       = y;
                    z_d       = z;
                    o_d       = '0;
                    k_d       = '0;
                    mac_clr_c = 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                mac_en_c = 1'b1;
                k_d      = k_q + KW'(1);
                if (k_q == KW'(K - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                mac_clr_c = 1'b1;
                k_d       = '0;
                if (o_q == OW'(LEN - K)) begin
                    state_d = S_DONE;
                end else begin
                    o_d     = o_q + OW'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_q == S_DONE);
    end

    // State, address latches, counters and registered done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            o_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            o_q     <= o_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    // Result write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_WRITE) begin
            out_mem[wr_addr_c] <= wr_data_c;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed table-driven checks of conv_engine plus
// hand-written reset, reset/start collision and back-to-back sequences.
module tb_conv_engine;

    localparam int PAT_ONES = 0;
    localparam int PAT_RAMP = 1;
    localparam int PAT_NEG  = 2;
    localparam int NOUT     = 13;

`ifdef CONV_RELU_EN
    localparam int NEG_EXP = 0;
`else
    localparam int NEG_EXP = -8;
`endif

    typedef struct {
        int         pat;
        logic [7:0] xa;
        logic [7:0] ya;
        logic [7:0] za;
        int         hold;
        int         exp0;
        int         step;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       done;

    int         pass_cnt;
    int         total_cnt;
    logic [19:0] shadow [0:255];
    vec_t        vecs [0:3];

    conv_engine #(
        .IN_FILE   (""),
        .FILT_FILE ("")
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .z     (z),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                PAT_ONES: begin dut.in_mem[i] = 8'h01;     dut.filt_mem[i] = 8'h01;    end
                PAT_RAMP: begin dut.in_mem[i] = 8'(i - 16); dut.filt_mem[i] = 8'(i + 1); end
                default:  begin dut.in_mem[i] = 8'hFF;     dut.filt_mem[i] = 8'h02;    end
            endcase
        end
    endtask

    // Start a run, hold start for 'hold' edges, watch done for 100 edges
    task automatic run(input logic [7:0] xa, input logic [7:0] ya, input logic [7:0] za,
                       input int hold, output int first, output int pulses);
        x = xa; y = ya; z = za; start = 1'b1;
        step();
        x = 8'hAA; y = 8'h55; z = 8'hCC;
        first = -1;
        pulses = 0;
        for (int e = 1; e <= 100; e++) begin
            start = (e < hold) ? 1'b1 : 1'b0;
            step();
            if (done) begin
                pulses++;
                if (first < 0) first = e;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int first;
        int pulses;
        int t1;
        int t2;
        int npulse;
        logic [7:0] a;
        logic [19:0] e;

        pass_cnt = 0;
        total_cnt = 0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        vecs[0] = '{pat: PAT_ONES, xa: 8'd16,  ya: 8'd0, za: 8'd16,  hold: 3, exp0: 4,       step: 0};
        vecs[1] = '{pat: PAT_RAMP, xa: 8'd16,  ya: 8'd0, za: 8'd16,  hold: 1, exp0: 20,      step: 10};
        vecs[2] = '{pat: PAT_NEG,  xa: 8'd16,  ya: 8'd0, za: 8'd16,  hold: 1, exp0: NEG_EXP, step: 0};
        vecs[3] = '{pat: PAT_ONES, xa: 8'd250, ya: 8'd0, za: 8'd250, hold: 1, exp0: 4,       step: 0};

        rst = 1'b1; start = 1'b0; x = '0; y = '0; z = '0;
        repeat (2) step();
        check("reset_done", 32'(done), 32'd0);
        check("reset_out_mem", 32'(dut.out_mem[16]), 32'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            preload(vecs[v].pat);
            run(vecs[v].xa, vecs[v].ya, vecs[v].za, vecs[v].hold, first, pulses);
            check($sformatf("v%0d_done_latency", v), 32'(first), 32'd66);
            check($sformatf("v%0d_done_pulses", v), 32'(pulses), 32'd1);
            for (int o = 0; o < NOUT; o++) begin
                a = vecs[v].za + 8'(o);
                e = 20'(vecs[v].exp0 + vecs[v].step * o);
                check($sformatf("v%0d_out[%0d]", v, a), 32'(dut.out_mem[a]), 32'(e));
                shadow[a] = e;
            end
            a = vecs[v].za + 8'(NOUT);
            check($sformatf("v%0d_untouched[%0d]", v, a), 32'(dut.out_mem[a]), 32'(shadow[a]));
        end

        // Reset sampled on the 21st edge after acceptance: outputs 0..3 only
        preload(PAT_ONES);
        x = 8'd16; y = 8'd0; z = 8'd16; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) npulse++;
        end
        check("rst_mid_no_done", 32'(npulse), 32'd0);
        for (int o = 0; o < NOUT; o++) begin
            a = 8'd16 + 8'(o);
            e = (o < 4) ? 20'd4 : shadow[a];
            check($sformatf("rst_mid_out[%0d]", a), 32'(dut.out_mem[a]), 32'(e));
            shadow[a] = e;
        end

        // Fresh run after the aborted one completes normally
        run(8'd16, 8'd0, 8'd16, 1, first, pulses);
        check("rerun_done_latency", 32'(first), 32'd66);
        check("rerun_done_pulses", 32'(pulses), 32'd1);
        for (int o = 0; o < NOUT; o += 4) begin
            a = 8'd16 + 8'(o);
            check($sformatf("rerun_out[%0d]", a), 32'(dut.out_mem[a]), 32'd4);
        end
        check("rerun_out[28]", 32'(dut.out_mem[28]), 32'd4);

        // Reset and start together: reset wins, no run starts
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        npulse = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done) npulse++;
        end
        check("rst_start_no_done", 32'(npulse), 32'd0);

        // Start held high: back-to-back runs
        x = 8'd16; y = 8'd0; z = 8'd16; start = 1'b1;
        step();
        t1 = -1; t2 = -1;
        for (int e2 = 1; e2 <= 300; e2++) begin
            if (t2 < 0) begin
                step();
                if (done) begin
                    if (t1 < 0) t1 = e2;
                    else begin
                        t2 = e2;
                        start = 1'b0;
                    end
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(t1), 32'd66);
        check("b2b_spacing", 32'(t2 - t1), 32'd67);
        repeat (80) step();
        check("b2b_quiet_after", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
